// File: rtl/mano_seq_if.sv
// Handshake bundle between the Mano sequence controller and its decode/memory side.
// The step_mode wire exists only when MANO_SEQ_SINGLE_STEP_EN is defined.
interface mano_seq_if #(
  parameter int SEQ_W = 3,
  parameter int IRQ_N = 2
);
  logic                    start;
  logic                    seq_clr_req;
  logic                    hlt_req;
  logic                    mem_req;
  logic                    mem_ack;
  logic [IRQ_N-1:0]        irq_flags;
  logic                    ien;
`ifdef MANO_SEQ_SINGLE_STEP_EN
  logic                    step_mode;
`endif
  logic [SEQ_W-1:0]        t;
  logic [(1<<SEQ_W)-1:0]   t_onehot;
  logic                    s_flag;
  logic                    r_flag;
  logic                    stall;
  logic                    inst_done;
  logic                    ien_clr;
  logic                    timeout_err;

  modport master (
`ifdef MANO_SEQ_SINGLE_STEP_EN
    output step_mode,
`endif
    output start, seq_clr_req, hlt_req, mem_req, mem_ack, irq_flags, ien,
    input  t, t_onehot, s_flag, r_flag, stall, inst_done, ien_clr, timeout_err
  );

  modport slave (
`ifdef MANO_SEQ_SINGLE_STEP_EN
    input  step_mode,
`endif
    input  start, seq_clr_req, hlt_req, mem_req, mem_ack, irq_flags, ien,
    output t, t_onehot, s_flag, r_flag, stall, inst_done, ien_clr, timeout_err
  );
endinterface

// File: rtl/mano_seq_ctrl.sv
// Mano CPU timing-state sequencer: T counter, S/R flags, memory stall and timeout.
// Optional single-step halting is enabled by defining MANO_SEQ_SINGLE_STEP_EN.
module mano_seq_ctrl #(
  parameter int SEQ_W      = 3,
  parameter int MAX_T      = 7,
  parameter int WAIT_MAX   = 15,
  parameter int IRQ_N      = 2,
  parameter int RUN_ON_RST = 1
) (
  input logic       mclk,
  input logic       mrst,
  mano_seq_if.slave bus
);
  localparam int NT   = 1 << SEQ_W;
  localparam int WC_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [SEQ_W-1:0] T_ZERO_C    = {SEQ_W{1'b0}};
  localparam logic [SEQ_W-1:0] T_MAX_C     = SEQ_W'(MAX_T);
  localparam logic [SEQ_W-1:0] T_IRQ_END_C = SEQ_W'(2);
  localparam logic [WC_W-1:0]  WAIT_MAX_C  = WC_W'(WAIT_MAX);
  localparam logic             S_RST_C     = (RUN_ON_RST != 0);
  localparam state_e           ST_RST_C    = (RUN_ON_RST != 0) ? ST_RUN : ST_HALT;

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  t_q, t_d;
  logic              s_q, s_d;
  logic              r_q, r_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              ienclr_q, ienclr_d;

  logic [SEQ_W-1:0]  adv_t_s;
  logic              adv_r_s;
  logic              adv_halt_s;
  logic              adv_done_s;
  logic              adv_ienclr_s;
  logic              step_halt_s;
  logic              to_halt_s;
  logic              stall_s;
  logic [NT-1:0]     onehot_s;

`ifdef MANO_SEQ_SINGLE_STEP_EN
  assign step_halt_s = bus.step_mode & adv_done_s;
`else
  assign step_halt_s = 1'b0;
`endif
  assign to_halt_s = adv_halt_s | step_halt_s;

  // State register
  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_q  <= ST_RST_C;
      t_q      <= T_ZERO_C;
      s_q      <= S_RST_C;
      r_q      <= 1'b0;
      wait_q   <= {WC_W{1'b0}};
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ienclr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      s_q      <= s_d;
      r_q      <= r_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      done_q   <= done_d;
      ienclr_q <= ienclr_d;
    end
  end

  // Non-stalled advance of T; halt beats instruction end, and R masks decode requests
  always_comb begin
    adv_t_s      = t_q + SEQ_W'(1);
    adv_r_s      = r_q;
    adv_halt_s   = 1'b0;
    adv_done_s   = 1'b0;
    adv_ienclr_s = 1'b0;
    if (!r_q && bus.hlt_req) begin
      adv_t_s    = T_ZERO_C;
      adv_halt_s = 1'b1;
      adv_done_s = 1'b1;
    end else if (!r_q && (bus.seq_clr_req || (t_q == T_MAX_C))) begin
      adv_t_s    = T_ZERO_C;
      adv_done_s = 1'b1;
      adv_r_s    = bus.ien & (|bus.irq_flags[IRQ_N-1:0]);
    end else if (r_q && (t_q == T_IRQ_END_C)) begin
      adv_t_s      = T_ZERO_C;
      adv_r_s      = 1'b0;
      adv_done_s   = 1'b1;
      adv_ienclr_s = 1'b1;
    end else begin
      adv_t_s = t_q + SEQ_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    s_d      = s_q;
    r_d      = r_q;
    wait_d   = wait_q;
    err_d    = err_q;
    done_d   = 1'b0;
    ienclr_d = 1'b0;
    case (state_q)
      ST_HALT: begin
        t_d = T_ZERO_C;
        if (bus.start) begin
          state_d = ST_RUN;
          s_d     = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ack) begin
          state_d = ST_WAIT;
          wait_d  = WC_W'(1);
        end else begin
          t_d      = adv_t_s;
          r_d      = adv_r_s;
          done_d   = adv_done_s;
          ienclr_d = adv_ienclr_s;
          s_d      = ~to_halt_s;
          state_d  = to_halt_s ? ST_HALT : ST_RUN;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          t_d      = adv_t_s;
          r_d      = adv_r_s;
          done_d   = adv_done_s;
          ienclr_d = adv_ienclr_s;
          s_d      = ~to_halt_s;
          state_d  = to_halt_s ? ST_HALT : ST_RUN;
          wait_d   = {WC_W{1'b0}};
        end else if (wait_q == WAIT_MAX_C) begin
          // Stuck access: abandon the instruction without an inst_done pulse
          state_d = ST_HALT;
          t_d     = T_ZERO_C;
          s_d     = 1'b0;
          err_d   = 1'b1;
          wait_d  = {WC_W{1'b0}};
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      default: begin
        state_d = ST_HALT;
        t_d     = T_ZERO_C;
        s_d     = 1'b0;
        wait_d  = {WC_W{1'b0}};
      end
    endcase
  end

  // Output decode
  always_comb begin
    stall_s  = 1'b0;
    onehot_s = {NT{1'b0}};
    case (state_q)
      ST_HALT: begin
        stall_s  = 1'b0;
        onehot_s = {NT{1'b0}};
      end
      ST_RUN: begin
        stall_s  = bus.mem_req & ~bus.mem_ack;
        onehot_s = NT'(1) << t_q;
      end
      ST_WAIT: begin
        stall_s  = ~bus.mem_ack;
        onehot_s = NT'(1) << t_q;
      end
      default: begin
        stall_s  = 1'b0;
        onehot_s = {NT{1'b0}};
      end
    endcase
  end

  assign bus.t           = t_q;
  assign bus.t_onehot    = onehot_s;
  assign bus.s_flag      = s_q;
  assign bus.r_flag      = r_q;
  assign bus.stall       = stall_s;
  assign bus.inst_done   = done_q;
  assign bus.ien_clr     = ienclr_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_mano_seq_ctrl.sv
// Scoreboard bench for mano_seq_ctrl: directed cycles push expected post-edge state.
module tb_mano_seq_ctrl;
  logic mclk = 1'b0;
  logic mrst = 1'b1;

  always #5 mclk = ~mclk;

  mano_seq_if #(.SEQ_W(3), .IRQ_N(2)) bus ();

  mano_seq_ctrl #(
    .SEQ_W(3), .MAX_T(7), .WAIT_MAX(15), .IRQ_N(2), .RUN_ON_RST(1)
  ) dut (
    .mclk(mclk),
    .mrst(mrst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [2:0] t;
    logic       s;
    logic       r;
    logic       d;
    logic       ic;
    logic       e;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       m_e;
  logic [7:0] m_oh;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Inputs are already set by the caller just after a falling edge.
  task automatic cyc(input logic [2:0] et, input logic es, input logic er, input logic ed,
                     input logic ei, input logic ee, input logic est);
    #1;
    check_val("stall", 32'(bus.stall), 32'(est));
    exp_q.push_back(exp_t'{t: et, s: es, r: er, d: ed, ic: ei, e: ee});
    @(negedge mclk);
  endtask

  // Compare registered outputs just after each rising edge
  always @(posedge mclk) begin
    #1;
    if (exp_q.size() != 0) begin
      m_e  = exp_q.pop_front();
      m_oh = m_e.s ? (8'd1 << m_e.t) : 8'd0;
      check_val("t",           32'(bus.t),           32'(m_e.t));
      check_val("s_flag",      32'(bus.s_flag),      32'(m_e.s));
      check_val("r_flag",      32'(bus.r_flag),      32'(m_e.r));
      check_val("inst_done",   32'(bus.inst_done),   32'(m_e.d));
      check_val("ien_clr",     32'(bus.ien_clr),     32'(m_e.ic));
      check_val("timeout_err", 32'(bus.timeout_err), 32'(m_e.e));
      check_val("t_onehot",    32'(bus.t_onehot),    32'(m_oh));
    end
  end

  initial begin
    bus.start       = 1'b0;
    bus.seq_clr_req = 1'b0;
    bus.hlt_req     = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.irq_flags   = 2'b00;
    bus.ien         = 1'b0;
`ifdef MANO_SEQ_SINGLE_STEP_EN
    bus.step_mode   = 1'b0;
`endif
    @(negedge mclk);
    @(negedge mclk);
    cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mrst = 1'b0;

    // Free run through a full wrap
    for (int i = 1; i <= 7; i++) cyc(3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Early instruction end with pending interrupt, then RT0..RT2
    for (int i = 1; i <= 3; i++) cyc(3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.seq_clr_req = 1'b1; bus.ien = 1'b1; bus.irq_flags = 2'b01;
    cyc(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.seq_clr_req = 1'b0;
    cyc(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.hlt_req = 1'b1; bus.seq_clr_req = 1'b1;
    cyc(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.hlt_req = 1'b0; bus.seq_clr_req = 1'b0;
    cyc(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.ien = 1'b0; bus.irq_flags = 2'b00;

    // Memory stall for three cycles at t=1
    cyc(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.mem_ack = 1'b1;
    cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_ack = 1'b0;

    // Timeout: RUN stall cycle plus WAIT counts 1..14, then expiry at 15
    for (int i = 0; i < 15; i++) cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.hlt_req = 1'b1;
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.hlt_req = 1'b0; bus.mem_req = 1'b0; bus.start = 1'b1;
    cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    cyc(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    cyc(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt wins over seq_clr_req, then restart
    bus.hlt_req = 1'b1; bus.seq_clr_req = 1'b1;
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.hlt_req = 1'b0; bus.seq_clr_req = 1'b0;
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    cyc(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Instruction end with flags set but IEN low takes no interrupt
    bus.seq_clr_req = 1'b1; bus.irq_flags = 2'b11;
    cyc(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.seq_clr_req = 1'b0; bus.irq_flags = 2'b00;
    cyc(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a WAIT
    bus.mem_req = 1'b1;
    cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mrst = 1'b1;
    cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mrst = 1'b0; bus.mem_req = 1'b0;
    cyc(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef MANO_SEQ_SINGLE_STEP_EN
    // Single step: each start runs one instruction then halts
    bus.step_mode = 1'b1;
    bus.seq_clr_req = 1'b1;
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.seq_clr_req = 1'b0;
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    cyc(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.seq_clr_req = 1'b1;
    cyc(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.seq_clr_req = 1'b0;
    cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.step_mode = 1'b0;
`endif

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
